// File: rtl/mem_line_responder.sv
// Memory-side line responder: fixed-latency fill / write-back service with a direct-indexed store.
// Build option MEM_ZERO_FILL_EN: misses return an all-zero line instead of the address pattern.
module mem_line_responder #(
  parameter int unsigned MEM_DELAY  = 20,
  parameter int unsigned LINE_BITS  = 512,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_BITS   = 18
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [LINE_BITS-1:0] resp_rdata,
  output logic                 busy
);

  localparam int unsigned WORDS = LINE_BITS / 32;
  localparam int unsigned DEPTH = 1 << INDEX_BITS;
  localparam logic [7:0]  LAST  = 8'(MEM_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                 state_q;
  logic [7:0]             cnt_q;
  logic                   we_q;
  logic [31:0]            addr_q;
  logic [LINE_BITS-1:0]   wdata_q;
  logic [LINE_BITS-1:0]   rdata_q;
  logic                   ready_q;
  logic                   valid_q;
  logic                   busy_q;
  logic [DEPTH-1:0]       written_q;

  logic [LINE_BITS-1:0]   line_q [DEPTH];
  logic [TAG_BITS-1:0]    tag_q  [DEPTH];

  logic [INDEX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]    tag;
  logic                   access;
  logic                   hit;
  logic [LINE_BITS-1:0]   miss_line;
  logic [LINE_BITS-1:0]   rdata_d;

  assign idx    = addr_q[6+INDEX_BITS-1:6];
  assign tag    = addr_q[31:6+INDEX_BITS];
  assign access = (state_q == WAIT) && (cnt_q == LAST);
  assign hit    = written_q[idx] && (tag_q[idx] == tag);

`ifdef MEM_ZERO_FILL_EN
  assign miss_line = '0;
`else
  always_comb begin
    miss_line = '0;
    for (int i = 0; i < WORDS; i++) begin
      miss_line[32*i +: 32] = addr_q + 32'(4 * i);
    end
  end
`endif

  always_comb begin
    rdata_d = miss_line;
    if (we_q) begin
      rdata_d = '0;
    end else if (hit) begin
      rdata_d = line_q[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      written_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= {req_addr[31:6], 6'b0};
            wdata_q <= req_wdata;
            cnt_q   <= '0;
            state_q <= WAIT;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (access) begin
            rdata_q <= rdata_d;
            valid_q <= 1'b1;
            state_q <= RESP;
            if (we_q) begin
              written_q[idx] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Store arrays carry no reset; validity lives in written_q.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      line_q[idx] <= wdata_q;
      tag_q[idx]  <= tag;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign busy       = busy_q;

endmodule
